neuron_lut_prog: RTL and testbench
==================================

// Module: neuron_lut_prog
// PURPOSE
//  Runtime-programmable LogicNets neuron: a 2^IN_BITS x OUT_BITS truth table held in distributed RAM.
//  It is the write side of the fixed per-neuron ROM tables (for example 8-bit M0 -> 2-bit M1).
//  The table is streamed in over a valid/ready config port, then evaluated per input vector with 1-cycle latency.
//  Sits in the layer wrapper in place of a hard-coded layerX_NY ROM, so retrained tables load without resynthesis.
// PARAMETERS
//  IN_BITS   8  table address width (fan-in x input bit-width)
//  OUT_BITS  2  neuron output width; entry width
//  CFG_W     8  config word width; must be a multiple of OUT_BITS; P = CFG_W/OUT_BITS entries per word
// PORTS
//  clk        in   1         single clock, all logic rising-edge
//  rst        in   1         synchronous, active-high reset
//  cfg_valid  in   1         config word offered
//  cfg_ready  out  1         config word accepted when cfg_valid & cfg_ready
//  cfg_data   in   CFG_W     packed table entries
//  cfg_last   in   1         marks final word of a table image
//  M0         in   IN_BITS   neuron input vector (table address)
//  M0_valid   in   1         M0 qualifies this cycle
//  M1         out  OUT_BITS  neuron output, registered
//  M1_valid   out  1         M1 qualifies this cycle
//  loaded     out  1         complete table image present
//  cfg_err    out  1         sticky: malformed image (cfg_last misplaced)
// BEHAVIOUR
//  Reset: state=EMPTY; loaded=0, cfg_err=0, M1=0, M1_valid=0, word counter=0; cfg_ready=1 from the first post-reset cycle.
//  Reset does not clear the RAM; contents are don't-care until a load completes.
//  Image layout: NW = 2^IN_BITS/P words (8/2/8 -> 64 words), sent in ascending address order.
//   Entry at address a sits in word a/P, bits [OUT_BITS*(a%P) +: OUT_BITS].
//  FSM:
//   EMPTY: a config handshake writes word 0, counter=1, go LOAD. If cfg_last is set on that word and NW>1: cfg_err=1, stay EMPTY.
//   LOAD: each handshake writes P entries at counter*P, counter++.
//    - cfg_last on word NW-1: go READY, loaded=1 next cycle.
//    - cfg_last before word NW-1, or word NW-1 arrives without cfg_last: cfg_err=1, counter=0, go EMPTY.
//   READY: a config handshake starts a reload. loaded=0 the cycle after the handshake, word 0 is written, go LOAD.
//  cfg_ready is always 1; no backpressure. Every accepted word is written the same cycle.
//  cfg_err clears only on rst.
//  Inference: M1_valid(t+1) = M0_valid(t) & loaded(t); M1(t+1) = table[M0(t)] when qualified, else M1 holds.
//   - Inputs offered while loaded=0 are dropped: no M1_valid, M1 unchanged.
//   - A same-cycle config write and M0 read use the pre-write table (read-first).
//   - Full throughput: one result per cycle, no stalls.
//  Reset mid-load: image abandoned, loaded=0, and a full reload is required.
//  Counter is clog2(NW) bits. An error at word NW-1 resets the counter rather than letting it wrap.
// STRUCTURE
//  Shared package neuron_lut_pkg: the cfg_state_t enum {EMPTY, LOAD, READY} and a function computing NW from the parameters.
//  Sub-module neuron_lut_ram: 2^IN_BITS x OUT_BITS with a P-entry-wide write port and one read port.
//   Registered read, read-first, (* ram_style="distributed" *).
//  Top level holds the FSM, word counter, error/loaded flags and the valid pipeline.
// TESTING
//  1. Reset, then M0=8'h00 with M0_valid=1 -> M1_valid stays 0, M1=2'b00, loaded=0.
//  2. Load 64 words where word w = {4{w[1:0]}}, cfg_last on word 63
//     -> loaded=1 one cycle after the handshake; M0=8'h05 gives M1=2'b01 one cycle later.
//  3. Load the layer1_N2 reference table, then sweep M0 0..255 back-to-back
//     -> M1 matches the ROM values (M0=8'h00->2'b01, 8'h03->2'b00, 8'hC3->2'b01); 256 consecutive M1_valid pulses.
//  4. Assert cfg_last on word 10 -> cfg_err=1, loaded=0, next word restarts at address 0.
//     Send 64 words without cfg_last on word 63 -> cfg_err=1, state EMPTY.
//  5. Assert rst after 30 words, then stream M0 -> no M1_valid until a full 64-word reload completes.
//  6. In READY, issue M0=8'h05 in the same cycle as a reload's first word -> M1 is the old-table value;
//     loaded=0 the cycle after the handshake.

Source files
------------

// File: rtl/neuron_lut_pkg.sv
// Shared types and sizing helpers for the runtime-programmable LogicNets neuron table.
package neuron_lut_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } cfg_state_t;

    // Number of config words in one complete table image.
    function automatic int calc_nw(input int in_bits, input int out_bits, input int cfg_w);
        return (1 << in_bits) / (cfg_w / out_bits);
    endfunction

    // Word counter width; kept at least one bit so a single-word image still has a counter.
    function automatic int cnt_width(input int nw);
        return (nw > 1) ? $clog2(nw) : 1;
    endfunction

endpackage

// File: rtl/neuron_lut_prog_if.sv
// Config stream and inference port bundle of the programmable neuron table.
interface neuron_lut_prog_if
    import neuron_lut_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2,
    parameter int CFG_W    = 8
) ();

    logic                cfg_valid;
    logic                cfg_ready;
    logic [CFG_W-1:0]    cfg_data;
    logic                cfg_last;
    logic [IN_BITS-1:0]  M0;
    logic                M0_valid;
    logic [OUT_BITS-1:0] M1;
    logic                M1_valid;
    logic                loaded;
    logic                cfg_err;

    modport master (
        output cfg_valid, cfg_data, cfg_last, M0, M0_valid,
        input  cfg_ready, M1, M1_valid, loaded, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_data, cfg_last, M0, M0_valid,
        output cfg_ready, M1, M1_valid, loaded, cfg_err
    );

endinterface

// File: rtl/neuron_lut_ram.sv
// Neuron truth table: P-entry-wide write port, registered read-first read port.
module neuron_lut_ram
    import neuron_lut_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2,
    parameter int CFG_W    = 8,
    parameter int WA_W     = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [WA_W-1:0]     waddr,
    input  logic [CFG_W-1:0]    wdata,
    input  logic                re,
    input  logic [IN_BITS-1:0]  raddr,
    output logic [OUT_BITS-1:0] rdata
);

    localparam int P       = CFG_W / OUT_BITS;
    localparam int ENTRIES = 1 << IN_BITS;

    (* ram_style = "distributed" *) logic [OUT_BITS-1:0] mem [ENTRIES];

    // Contents survive reset; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int p = 0; p < P; p++) begin
                mem[IN_BITS'(int'(waddr) * P + p)] <= wdata[p*OUT_BITS +: OUT_BITS];
            end
        end
    end

    // Reads sample mem before this edge's writes land, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/neuron_lut_prog.sv
// Runtime-programmable LogicNets neuron: streamed table load plus 1-cycle table evaluation.
//
//   state | meaning
//   EMPTY | no valid image; next accepted word is word 0
//   LOAD  | image in progress; cnt is the index of the next word
//   READY | complete image present; a new word starts a reload at word 0
module neuron_lut_prog
    import neuron_lut_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2,
    parameter int CFG_W    = 8
) (
    input logic              clk,
    input logic              rst,
    neuron_lut_prog_if.slave bus
);

    localparam int NW    = calc_nw(IN_BITS, OUT_BITS, CFG_W);
    localparam int CNT_W = cnt_width(NW);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NW - 1);

    localparam logic [1:0] S_EMPTY = EMPTY;
    localparam logic [1:0] S_LOAD  = LOAD;
    localparam logic [1:0] S_READY = READY;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] widx;
    logic             at_last;
    logic             hs;
    logic             loaded;
    logic             cfg_err;
    logic             m1_valid;
    logic             rd_en;

    assign hs      = bus.cfg_valid;
    assign widx    = (state == S_LOAD) ? cnt : '0;
    assign at_last = (widx == LAST_IDX);
    assign loaded  = (state == S_READY);
    assign rd_en   = bus.M0_valid & loaded;

    // Outside LOAD an accepted word is always word 0, so one decision tree covers every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_EMPTY;
            cnt      <= '0;
            cfg_err  <= 1'b0;
            m1_valid <= 1'b0;
        end else begin
            m1_valid <= rd_en;
            if (hs) begin
                if (bus.cfg_last && at_last) begin
                    state <= S_READY;
                    cnt   <= '0;
                end else if (bus.cfg_last || at_last) begin
                    state   <= S_EMPTY;
                    cnt     <= '0;
                    cfg_err <= 1'b1;
                end else begin
                    state <= S_LOAD;
                    cnt   <= widx + CNT_W'(1);
                end
            end
        end
    end

    neuron_lut_ram #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS),
        .CFG_W    (CFG_W),
        .WA_W     (CNT_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (hs),
        .waddr (widx),
        .wdata (bus.cfg_data),
        .re    (rd_en),
        .raddr (bus.M0),
        .rdata (bus.M1)
    );

    assign bus.cfg_ready = 1'b1;
    assign bus.M1_valid  = m1_valid;
    assign bus.loaded    = loaded;
    assign bus.cfg_err   = cfg_err;

endmodule

// File: tb/tb_neuron_lut_prog.sv
// Self-checking bench for neuron_lut_prog against an array-based table model.
module tb_neuron_lut_prog;
    import neuron_lut_pkg::*;

    localparam int IN_BITS  = 8;
    localparam int OUT_BITS = 2;
    localparam int CFG_W    = 8;
    localparam int P        = CFG_W / OUT_BITS;
    localparam int NW       = calc_nw(IN_BITS, OUT_BITS, CFG_W);
    localparam int ENTRIES  = 1 << IN_BITS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    neuron_lut_prog_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .CFG_W(CFG_W)) bus ();

    neuron_lut_prog #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .CFG_W(CFG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: the table as an array, plus image progress and the output flags.
    logic [OUT_BITS-1:0] tbl [ENTRIES];
    logic [CFG_W-1:0]    img [NW];
    int                  m_words;
    bit                  m_loaded;
    bit                  m_err;
    bit                  m_m1v;
    logic [OUT_BITS-1:0] m_m1;

    int total = 0;
    int bad   = 0;

    task automatic cycle(input bit cv, input logic [CFG_W-1:0] cd, input bit cl,
                         input bit mv, input logic [IN_BITS-1:0] m0);
        bus.cfg_valid = cv;
        bus.cfg_data  = cd;
        bus.cfg_last  = cl;
        bus.M0_valid  = mv;
        bus.M0        = m0;
        m_m1v = mv && m_loaded;
        if (m_m1v) m_m1 = tbl[m0];
        if (cv) begin
            for (int p = 0; p < P; p++) tbl[m_words*P + p] = cd[p*OUT_BITS +: OUT_BITS];
            m_loaded = 1'b0;
            if (cl && m_words == NW-1) begin
                m_loaded = 1'b1;
                m_words  = 0;
            end else if (cl || m_words == NW-1) begin
                m_err   = 1'b1;
                m_words = 0;
            end else begin
                m_words++;
            end
        end
        @(posedge clk);
        #1;
        bus.cfg_valid = 1'b0;
        bus.cfg_last  = 1'b0;
        bus.M0_valid  = 1'b0;
    endtask

    task automatic apply_reset();
        bus.cfg_valid = 1'b0;
        bus.cfg_last  = 1'b0;
        bus.M0_valid  = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_words  = 0;
        m_loaded = 1'b0;
        m_err    = 1'b0;
        m_m1v    = 1'b0;
        m_m1     = '0;
    endtask

    task automatic send_words(input int first, input int last_w, input int last_flag_at);
        for (int w = first; w <= last_w; w++) cycle(1'b1, img[w], (w == last_flag_at), 1'b0, '0);
    endtask

    task automatic random_image();
        for (int w = 0; w < NW; w++) img[w] = CFG_W'($urandom);
    endtask

    task automatic set_entry(input int a, input logic [OUT_BITS-1:0] v);
        img[a/P][(a%P)*OUT_BITS +: OUT_BITS] = v;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (bus.loaded !== 1'b0) begin bad++; $display("FAIL rst_loaded: got %b want 0", bus.loaded); end
        total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", bus.cfg_err); end
        total++; if (bus.M1 !== 2'b00) begin bad++; $display("FAIL rst_m1: got %b want 00", bus.M1); end
        total++; if (bus.M1_valid !== 1'b0) begin bad++; $display("FAIL rst_m1v: got %b want 0", bus.M1_valid); end
        total++; if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", bus.cfg_ready); end
        cycle(1'b0, '0, 1'b0, 1'b1, 8'h00);
        total++; if (bus.M1_valid !== 1'b0) begin bad++; $display("FAIL empty_m1v: got %b want 0", bus.M1_valid); end
        total++; if (bus.M1 !== 2'b00) begin bad++; $display("FAIL empty_m1: got %b want 00", bus.M1); end
        total++; if (bus.loaded !== 1'b0) begin bad++; $display("FAIL empty_loaded: got %b want 0", bus.loaded); end
    endtask

    task automatic test_pattern_load();
        for (int w = 0; w < NW; w++) img[w] = {4{2'(w)}};
        send_words(0, NW-2, -1);
        total++; if (bus.loaded !== 1'b0) begin bad++; $display("FAIL pat_early_loaded: got %b want 0", bus.loaded); end
        send_words(NW-1, NW-1, NW-1);
        total++; if (bus.loaded !== 1'b1) begin bad++; $display("FAIL pat_loaded: got %b want 1", bus.loaded); end
        total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL pat_err: got %b want 0", bus.cfg_err); end
        cycle(1'b0, '0, 1'b0, 1'b1, 8'h05);
        total++; if (bus.M1_valid !== 1'b1) begin bad++; $display("FAIL pat_m1v: got %b want 1", bus.M1_valid); end
        total++; if (bus.M1 !== 2'b01) begin bad++; $display("FAIL pat_m1: got %b want 01", bus.M1); end
    endtask

    task automatic test_ref_sweep();
        logic [OUT_BITS-1:0] got [ENTRIES];
        int pulses = 0;
        random_image();
        set_entry(8'h00, 2'b01);
        set_entry(8'h03, 2'b00);
        set_entry(8'hC3, 2'b01);
        send_words(0, NW-1, NW-1);
        total++; if (bus.loaded !== 1'b1) begin bad++; $display("FAIL ref_loaded: got %b want 1", bus.loaded); end
        for (int i = 0; i < ENTRIES; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b1, IN_BITS'(i));
            got[i] = bus.M1;
            if (bus.M1_valid === 1'b1) pulses++;
            total++; if (bus.M1 !== m_m1) begin bad++; $display("FAIL sweep_m1[%0d]: got %b want %b", i, bus.M1, m_m1); end
        end
        total++; if (pulses != ENTRIES) begin bad++; $display("FAIL sweep_pulses: got %0d want %0d", pulses, ENTRIES); end
        total++; if (got[8'h00] !== 2'b01) begin bad++; $display("FAIL ref_00: got %b want 01", got[8'h00]); end
        total++; if (got[8'h03] !== 2'b00) begin bad++; $display("FAIL ref_03: got %b want 00", got[8'h03]); end
        total++; if (got[8'hC3] !== 2'b01) begin bad++; $display("FAIL ref_c3: got %b want 01", got[8'hC3]); end
        cycle(1'b0, '0, 1'b0, 1'b0, 8'h00);
        total++; if (bus.M1_valid !== 1'b0) begin bad++; $display("FAIL idle_m1v: got %b want 0", bus.M1_valid); end
        total++; if (bus.M1 !== got[ENTRIES-1]) begin bad++; $display("FAIL idle_hold: got %b want %b", bus.M1, got[ENTRIES-1]); end
    endtask

    task automatic test_errors();
        random_image();
        send_words(0, 10, 10);
        total++; if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL early_last_err: got %b want 1", bus.cfg_err); end
        total++; if (bus.loaded !== 1'b0) begin bad++; $display("FAIL early_last_loaded: got %b want 0", bus.loaded); end
        random_image();
        send_words(0, NW-1, NW-1);
        total++; if (bus.loaded !== 1'b1) begin bad++; $display("FAIL restart_loaded: got %b want 1", bus.loaded); end
        for (int a = 0; a < 16; a++) begin
            cycle(1'b0, '0, 1'b0, 1'b1, IN_BITS'(a));
            total++; if (bus.M1 !== m_m1) begin bad++; $display("FAIL restart_m1[%0d]: got %b want %b", a, bus.M1, m_m1); end
        end
        apply_reset();
        random_image();
        send_words(0, NW-1, -1);
        total++; if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL missing_last_err: got %b want 1", bus.cfg_err); end
        total++; if (bus.loaded !== 1'b0) begin bad++; $display("FAIL missing_last_loaded: got %b want 0", bus.loaded); end
        send_words(0, NW-2, -1);
        total++; if (bus.loaded !== 1'b0) begin bad++; $display("FAIL after_err_early: got %b want 0", bus.loaded); end
        send_words(NW-1, NW-1, NW-1);
        total++; if (bus.loaded !== 1'b1) begin bad++; $display("FAIL after_err_loaded: got %b want 1", bus.loaded); end
        total++; if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", bus.cfg_err); end
    endtask

    task automatic test_reset_midload();
        random_image();
        send_words(0, 29, -1);
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b1, IN_BITS'($urandom));
            total++; if (bus.M1_valid !== 1'b0) begin bad++; $display("FAIL midrst_m1v: got %b want 0", bus.M1_valid); end
        end
        for (int w = 0; w < NW; w++) begin
            cycle(1'b1, img[w], (w == NW-1), 1'b1, IN_BITS'($urandom));
            total++; if (bus.M1_valid !== m_m1v) begin bad++; $display("FAIL reload_m1v[%0d]: got %b want %b", w, bus.M1_valid, m_m1v); end
        end
        total++; if (bus.loaded !== 1'b1) begin bad++; $display("FAIL reload_loaded: got %b want 1", bus.loaded); end
        cycle(1'b0, '0, 1'b0, 1'b1, 8'h2A);
        total++; if (bus.M1_valid !== 1'b1) begin bad++; $display("FAIL reload_m1v_on: got %b want 1", bus.M1_valid); end
        total++; if (bus.M1 !== m_m1) begin bad++; $display("FAIL reload_m1: got %b want %b", bus.M1, m_m1); end
    endtask

    task automatic test_read_first();
        logic [OUT_BITS-1:0] old_v;
        logic [OUT_BITS-1:0] new_v;
        old_v = tbl[5];
        new_v = ~old_v;
        random_image();
        set_entry(5, new_v);
        cycle(1'b1, img[0], 1'b0, 1'b1, 8'h05);
        total++; if (bus.M1 !== old_v) begin bad++; $display("FAIL rf_old: got %b want %b", bus.M1, old_v); end
        total++; if (bus.M1_valid !== 1'b1) begin bad++; $display("FAIL rf_m1v: got %b want 1", bus.M1_valid); end
        total++; if (bus.loaded !== 1'b0) begin bad++; $display("FAIL rf_loaded: got %b want 0", bus.loaded); end
        send_words(1, NW-1, NW-1);
        cycle(1'b0, '0, 1'b0, 1'b1, 8'h05);
        total++; if (bus.M1 !== new_v) begin bad++; $display("FAIL rf_new: got %b want %b", bus.M1, new_v); end
    endtask

    task automatic test_random();
        bit cv, cl;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(299) == 0) apply_reset();
            cv = 1'($urandom);
            cl = (m_words == NW-1) ? ($urandom_range(7) != 0) : ($urandom_range(63) == 0);
            cycle(cv, CFG_W'($urandom), cl, 1'($urandom), IN_BITS'($urandom));
            total++; if (bus.M1_valid !== m_m1v) begin bad++; $display("FAIL rnd_m1v[%0d]: got %b want %b", i, bus.M1_valid, m_m1v); end
            total++; if (bus.M1 !== m_m1) begin bad++; $display("FAIL rnd_m1[%0d]: got %b want %b", i, bus.M1, m_m1); end
            total++; if (bus.loaded !== m_loaded) begin bad++; $display("FAIL rnd_loaded[%0d]: got %b want %b", i, bus.loaded, m_loaded); end
            total++; if (bus.cfg_err !== m_err) begin bad++; $display("FAIL rnd_err[%0d]: got %b want %b", i, bus.cfg_err, m_err); end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;
        bus.cfg_last  = 1'b0;
        bus.M0        = '0;
        bus.M0_valid  = 1'b0;
        test_reset();
        test_pattern_load();
        test_ref_sweep();
        test_errors();
        test_reset_midload();
        test_read_first();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
